// File: rtl/tick_scheduler.sv
// Shared-prescaler tick scheduler: one prescaler drives NCH programmable tick/divided-clock channels.
// Optional macro TICK_SCHED_CLKOUT_EN builds the clk_out toggle registers; otherwise clk_out is tied low.
module tick_scheduler #(
  parameter int unsigned PRESCALE = 100,
  parameter int unsigned NCH      = 4,
  parameter int unsigned PW       = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [2:0]     cfg_ch,
  input  logic [PW-1:0]  cfg_period,
  input  logic           cfg_enable,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] active
);

  localparam logic [31:0] PS_LAST = 32'(PRESCALE - 1);

  typedef enum logic {ST_IDLE, ST_PEND} state_t;

  logic [31:0]   r_pcnt;
  logic          w_base_tick;
  state_t        r_state, w_state_nxt;
  logic          w_accept, w_apply;
  logic          r_cfg_ready;
  logic [2:0]    r_pend_ch;
  logic [PW-1:0] r_pend_per;
  logic          r_pend_en;
  logic          w_new_en;

  logic [NCH-1:0] r_en, r_tick, w_hit, w_wrap;
  logic [PW-1:0]  r_per [NCH];
  logic [PW-1:0]  r_cnt [NCH];

  assign w_base_tick = (r_pcnt == PS_LAST);
  assign w_new_en    = r_pend_en && (r_pend_per != '0);

  // Free-running prescaler
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_pcnt <= '0;
    else if (w_base_tick) r_pcnt <= '0;
    else                  r_pcnt <= r_pcnt + 32'd1;
  end

  // Single pending-slot handshake: accept when idle, apply on the next base tick
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_apply     = 1'b0;
    case (r_state)
      ST_IDLE: if (cfg_valid) begin
        w_accept    = 1'b1;
        w_state_nxt = ST_PEND;
      end
      ST_PEND: if (w_base_tick) begin
        w_apply     = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cfg_ready <= 1'b1;
      r_pend_ch   <= '0;
      r_pend_per  <= '0;
      r_pend_en   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cfg_ready <= (w_state_nxt == ST_IDLE);
      if (w_accept) begin
        r_pend_ch  <= cfg_ch;
        r_pend_per <= cfg_period;
        r_pend_en  <= cfg_enable;
      end
    end
  end

  // Full 3-bit compare so out-of-range channels match nothing and are dropped
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      w_hit[c]  = w_apply && (r_pend_ch == 3'(c));
      w_wrap[c] = w_base_tick && r_en[c] && (r_cnt[c] == r_per[c] - PW'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en   <= '0;
      r_tick <= '0;
      for (int c = 0; c < NCH; c++) begin
        r_per[c] <= '0;
        r_cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (w_hit[c]) begin
          r_per[c]  <= r_pend_per;
          r_en[c]   <= w_new_en;
          r_cnt[c]  <= '0;
          r_tick[c] <= 1'b0;
        end else begin
          r_tick[c] <= w_wrap[c];
          if (w_base_tick && r_en[c])
            r_cnt[c] <= w_wrap[c] ? '0 : r_cnt[c] + PW'(1);
        end
      end
    end
  end

`ifdef TICK_SCHED_CLKOUT_EN
  logic [NCH-1:0] r_clk_out;

  // Toggle on each wrap; an apply holds the level, or clears it when disabling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_clk_out <= '0;
    else begin
      for (int c = 0; c < NCH; c++) begin
        if (w_hit[c]) begin
          if (!w_new_en) r_clk_out[c] <= 1'b0;
        end else if (w_wrap[c]) begin
          r_clk_out[c] <= ~r_clk_out[c];
        end
      end
    end
  end

  assign clk_out = r_clk_out;
`else
  assign clk_out = '0;
`endif

  assign tick      = r_tick;
  assign active    = r_en;
  assign cfg_ready = r_cfg_ready;

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: randomized and directed configs checked against an edge-count arithmetic model.
module tb_tick_scheduler;
  localparam int PS  = 4;
  localparam int NCH = 4;
`ifdef TICK_SCHED_CLKOUT_EN
  localparam bit CLKO = 1'b1;
`else
  localparam bit CLKO = 1'b0;
`endif

  logic           clk, rst_n, cfg_valid, cfg_ready, cfg_enable;
  logic [2:0]     cfg_ch;
  logic [15:0]    cfg_period;
  logic [NCH-1:0] tick, clk_out, active;

  tick_scheduler #(.PRESCALE(PS), .NCH(NCH), .PW(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_period(cfg_period), .cfg_enable(cfg_enable),
    .tick(tick), .clk_out(clk_out), .active(active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: per channel, the apply edge, period and clk_out level at apply; ticks follow by arithmetic
  int e;
  int m_en [NCH];
  int m_per [NCH];
  int m_a [NCH];
  int m_base [NCH];
  bit m_pend;
  int m_ap, m_pch, m_pper, m_pen;
  int nchk, nbad;

  function automatic int clk_m(int c, int x);
    if (!CLKO || m_en[c] == 0) return 0;
    return m_base[c] ^ (((x - m_a[c]) / (m_per[c] * PS)) % 2);
  endfunction

  function automatic bit tick_m(int c, int x);
    return (m_en[c] != 0) && (x > m_a[c]) && (((x - m_a[c]) % (m_per[c] * PS)) == 0);
  endfunction

  function automatic logic [12:0] exp_vec();
    logic [3:0] t, k, a;
    for (int i = 0; i < NCH; i++) begin
      t[i] = tick_m(i, e);
      k[i] = (clk_m(i, e) != 0);
      a[i] = (m_en[i] != 0);
    end
    return {!m_pend, a, k, t};
  endfunction

  function automatic logic [12:0] obs_vec();
    return {cfg_ready, active, clk_out, tick};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) begin
      m_en[i] = 0; m_per[i] = 0; m_a[i] = 0; m_base[i] = 0;
    end
    m_pend = 1'b0;
  endtask

  // Drive inputs for one clock, advance the model past the edge, land 1 time unit after it
  task automatic adv(input bit v, input int ch, input int per, input int en);
    bit acc;
    int ne, nb;
    cfg_valid = v; cfg_ch = 3'(ch); cfg_period = 16'(per); cfg_enable = en[0];
    @(posedge clk);
    e++;
    acc = v && !m_pend;
    if (m_pend && e == m_ap) begin
      m_pend = 1'b0;
      if (m_pch < NCH) begin
        ne = (m_pen != 0 && m_pper != 0) ? 1 : 0;
        nb = (ne != 0) ? clk_m(m_pch, e - 1) : 0;
        m_en[m_pch] = ne; m_per[m_pch] = m_pper; m_a[m_pch] = e; m_base[m_pch] = nb;
      end
    end
    if (acc) begin
      m_pend = 1'b1; m_ap = (e / PS + 1) * PS;
      m_pch = ch; m_pper = per; m_pen = en;
    end
    #1;
  endtask

  task automatic send(input int ch, input int per, input int en);
    bit done = 1'b0;
    for (int k = 0; k < 16 && !done; k++) begin
      done = !m_pend;
      adv(1'b1, ch, per, en);
    end
    cfg_valid = 1'b0;
    if (!done) begin
      nchk++; nbad++;
      $display("FAIL send_timeout ch=%0d got=no_accept exp=accept", ch);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    e = 0;
  endtask

  task automatic test_reset();
    logic [12:0] x;
    for (int k = 0; k < 10; k++) begin
      adv(1'b0, 0, 0, 0);
      x = exp_vec(); nchk++;
      if (obs_vec() !== x) begin nbad++; $display("FAIL reset_idle cyc=%0d got=%b exp=%b", e, obs_vec(), x); end
    end
    send(0, 1, 1);
    for (int k = 0; k < 6; k++) adv(1'b0, 0, 0, 0);
    #2 rst_n = 1'b0; model_clear();
    #1 nchk++;
    if (obs_vec() !== 13'b1_0000_0000_0000) begin
      nbad++; $display("FAIL reset_async got=%b exp=%b", obs_vec(), 13'b1_0000_0000_0000);
    end
    release_reset();
    for (int k = 0; k < 100; k++) begin
      adv(1'b0, 0, 0, 0);
      x = exp_vec(); nchk++;
      if (obs_vec() !== x) begin nbad++; $display("FAIL reset_quiet cyc=%0d got=%b exp=%b", e, obs_vec(), x); end
    end
  endtask

  task automatic test_basic();
    logic [12:0] x;
    adv(1'b1, 0, 3, 1);
    for (int k = 0; k < 60; k++) begin
      adv(1'b0, 0, 0, 0);
      x = exp_vec(); nchk++;
      if (obs_vec() !== x) begin nbad++; $display("FAIL basic cyc=%0d got=%b exp=%b", e, obs_vec(), x); end
    end
  endtask

  task automatic test_independent();
    logic [12:0] x;
    send(1, 1, 1);
    send(2, 5, 1);
    for (int k = 0; k < 60; k++) begin
      adv(1'b0, 0, 0, 0);
      x = exp_vec(); nchk++;
      if (obs_vec() !== x) begin nbad++; $display("FAIL independent cyc=%0d got=%b exp=%b", e, obs_vec(), x); end
    end
  endtask

  task automatic test_wrap_apply();
    logic [12:0] x;
    // Accept two edges before a ch0 wrap so the apply lands on the wrap edge
    for (int k = 0; k < 40 && (((e + 1 - m_a[0]) % 12) != 10); k++) adv(1'b0, 0, 0, 0);
    adv(1'b1, 0, 2, 1);
    for (int k = 0; k < 40; k++) begin
      adv(1'b0, 0, 0, 0);
      x = exp_vec(); nchk++;
      if (obs_vec() !== x) begin nbad++; $display("FAIL wrap_apply cyc=%0d got=%b exp=%b", e, obs_vec(), x); end
    end
  endtask

  task automatic test_disable();
    logic [12:0] x;
    send(1, 7, 0);
    send(2, 0, 1);
    send(5, 3, 1);
    for (int k = 0; k < 40; k++) begin
      adv(1'b0, 0, 0, 0);
      x = exp_vec(); nchk++;
      if (obs_vec() !== x) begin nbad++; $display("FAIL disable cyc=%0d got=%b exp=%b", e, obs_vec(), x); end
    end
  endtask

  task automatic test_random();
    logic [12:0] x;
    for (int k = 0; k < 400; k++) begin
      adv(($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)), int'($urandom_range(0, 5)),
          int'($urandom_range(0, 3) != 0));
      x = exp_vec(); nchk++;
      if (obs_vec() !== x) begin nbad++; $display("FAIL random cyc=%0d got=%b exp=%b", e, obs_vec(), x); end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset_handshake();
    logic [12:0] x;
    for (int k = 0; k < 8; k++) adv(1'b0, 0, 0, 0);
    send(3, 2, 1);
    #2 rst_n = 1'b0; model_clear();
    release_reset();
    for (int k = 0; k < 30; k++) begin
      adv(1'b0, 0, 0, 0);
      x = exp_vec(); nchk++;
      if (obs_vec() !== x) begin nbad++; $display("FAIL reset_handshake cyc=%0d got=%b exp=%b", e, obs_vec(), x); end
    end
  endtask

  initial begin
    nchk = 0; nbad = 0; e = 0;
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_enable = 1'b0;
    model_clear();
    release_reset();
    test_reset();
    test_basic();
    test_independent();
    test_wrap_apply();
    test_disable();
    test_random();
    test_reset_handshake();
    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end
endmodule
